// File: rtl/banco_registros_pkg.sv
// ============================================================================
// banco_pkg : shared constants, depth helper and word type for banco_registros
// Rev 1.0
// ============================================================================
`default_nettype none

package banco_pkg;

  localparam int WIDTH_DEF = 14;
  localparam int AW_DEF    = 3;

  function automatic int DEPTH_OF(input int aw);
    return 1 << aw;
  endfunction

  typedef logic [WIDTH_DEF-1:0] palabra_t;

endpackage

`default_nettype wire

// File: rtl/banco_registros_puerto_lectura.sv
// ============================================================================
// puerto_lectura : registered read port with enable, write-first forwarding
// Rev 1.0
// ============================================================================
`default_nettype none

module puerto_lectura
  import banco_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int AW      = AW_DEF,
  parameter int ZERO_R0 = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             re_i,
  input  logic [AW-1:0]    ra_i,
  input  logic [WIDTH-1:0] rd_i,
  input  logic             we_i,
  input  logic [AW-1:0]    wa_i,
  input  logic [WIDTH-1:0] wd_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // we_i is the already-qualified write, so a dropped r0 write never forwards
  always_comb begin
    q_d = q_q;
    if (re_i) begin
      if ((ZERO_R0 != 0) && (ra_i == '0)) begin
        q_d = '0;
      end else if (we_i && (wa_i == ra_i)) begin
        q_d = wd_i;
      end else begin
        q_d = rd_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

`default_nettype wire

// File: rtl/banco_registros.sv
// ============================================================================
// banco_registros : 2**AW x WIDTH register file, 1 write port, 2 read ports
// Rev 1.0
// ============================================================================
`default_nettype none

module banco_registros
  import banco_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int AW      = AW_DEF,
  parameter int ZERO_R0 = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [WIDTH-1:0]    wd,
  input  logic                re_a,
  input  logic [AW-1:0]       ra_a,
  output logic [WIDTH-1:0]    qa,
  input  logic                re_b,
  input  logic [AW-1:0]       ra_b,
  output logic [WIDTH-1:0]    qb,
  output logic [(2**AW)-1:0]  valido
);

  localparam int DEPTH = DEPTH_OF(AW);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] valido_q;
  logic             w_we_eff;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  assign w_we_eff = we && !((ZERO_R0 != 0) && (wa == '0));

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        regs_q[i]   <= '0;
        valido_q[i] <= 1'b0;
      end else if (w_we_eff && (wa == AW'(i))) begin
        regs_q[i]   <= wd;
        valido_q[i] <= 1'b1;
      end
    end
  end

  assign w_rd_a = regs_q[ra_a];
  assign w_rd_b = regs_q[ra_b];
  assign valido = valido_q;

  puerto_lectura #(.WIDTH(WIDTH), .AW(AW), .ZERO_R0(ZERO_R0)) u_puerto_a (
    .clk  (clk),
    .rst  (rst),
    .re_i (re_a),
    .ra_i (ra_a),
    .rd_i (w_rd_a),
    .we_i (w_we_eff),
    .wa_i (wa),
    .wd_i (wd),
    .q_o  (qa)
  );

  puerto_lectura #(.WIDTH(WIDTH), .AW(AW), .ZERO_R0(ZERO_R0)) u_puerto_b (
    .clk  (clk),
    .rst  (rst),
    .re_i (re_b),
    .ra_i (ra_b),
    .rd_i (w_rd_b),
    .we_i (w_we_eff),
    .wa_i (wa),
    .wd_i (wd),
    .q_o  (qb)
  );

endmodule

`default_nettype wire

// File: doc/banco_registros.md
Name: banco_registros

Overview:
- Parametrised successor to the single 14-bit enabled register: a bank of 2**AW data registers with one write port and two registered read ports.
- Serves as the datapath register file of the ISA core, with a clear-all reset and same-cycle write-to-read forwarding.
- Tracks which registers have been written since reset.
- Sits between the instruction decoder (addresses, enables) and the ALU (operands qa/qb).

Parameters:
- WIDTH, 14, data width of every register and port.
- AW, 3, address width; DEPTH = 2**AW registers (default 8).
- ZERO_R0, 1, when 1, register 0 is hard-wired to zero and writes to it are ignored.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  WIDTH  write data.
- re_a  in  1  read enable, port A.
- ra_a  in  AW  read address, port A.
- qa  out  WIDTH  registered read data, port A.
- re_b  in  1  read enable, port B.
- ra_b  in  AW  read address, port B.
- qb  out  WIDTH  registered read data, port B.
- valido  out  DEPTH  bit i = 1 once register i has been written since reset.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. Nothing is asynchronous.
- Priority: rst over write and reads.
- Reset: rst=1 at a rising edge sets all DEPTH registers, qa, qb and valido to 0 in that single edge.
- rst held multiple cycles keeps everything at 0; we/re are ignored.
- No initial-value reliance: state after power-up is undefined until the first rst.
- Write: at an edge with rst=0 and we=1, reg[wa] <= wd and valido[wa] <= 1.
- Write exception: if ZERO_R0=1 and wa=0, the write is dropped and valido[0] stays 0.
- Read latency: 1 cycle. At an edge with re_a=1, qa <= the current value of reg[ra_a]. Port B is identical with re_b/ra_b/qb.
- re_x=0 holds qx at its previous value (same enable semantics as the legacy register).
- Forwarding (write-first): if the same edge has an effective write with wa=ra_x and re_x=1, qx <= wd, not the old contents. Applies independently to both ports.
- Both ports may read the same address in the same cycle; both return identical data.
- ZERO_R0=1: a read of address 0 always returns 0, including under a same-cycle write to address 0.
- Width: no arithmetic; data is copied bit-exact at WIDTH bits. Addresses are exact, so no out-of-range case exists (DEPTH = 2**AW).
- Reset mid-operation: an edge with rst=1 and we=1 discards the write; a read pending with re=1 returns 0 on the next cycle's qx.

Decomposition:
- Shared package banco_pkg holds:
  - default constants WIDTH_DEF=14, AW_DEF=3;
  - function DEPTH_OF(aw);
  - typedef palabra_t = logic [WIDTH_DEF-1:0].
- One natural sub-module: puerto_lectura (registered read with enable and forwarding mux), instantiated twice.
- Storage and write logic stay in the top.

Test Plan:
- Reset: load junk into all registers, pulse rst for 1 cycle -> next cycle every register reads 0, qa=qb=0, valido=8'h00.
- Write/read latency: we=1 wa=3 wd=14'h1ABC; next cycle re_a=1 ra_a=3 -> qa=14'h1ABC one edge later; valido=8'h08.
- Forwarding: reg5=14'h0011; same cycle we=1 wa=5 wd=14'h2222, re_a=1 ra_a=5, re_b=1 ra_b=5 -> qa=qb=14'h2222 after that edge.
- Hold: qa=14'h0F0F, then re_a=0 for 3 cycles while writing reg[ra_a]=14'h3FFF -> qa stays 14'h0F0F; re_a=1 -> qa=14'h3FFF.
- R0: ZERO_R0=1, we=1 wa=0 wd=14'h3FFF with re_b=1 ra_b=0 -> qb=0, valido[0]=0. With ZERO_R0=0 the same stimulus gives qb=14'h3FFF, valido[0]=1.
- Reset collision: rst=1 together with we=1 wa=2 wd=14'h0555 and re_a=1 ra_a=2 -> qa=0, reg2=0, valido[2]=0 after the edge.
